twiddle_mult_pipe: RTL and testbench
====================================

Name: twiddle_mult_pipe

Overview:
- Parametrised, fully pipelined complex twiddle multiplier for the FFT butterfly stages; successor to the fixed 8-bit, start-triggered twiddle multiplier.
- Computes (x + j·y)·(c + j·s) with the 3-multiplier form: Z = c·(x−y), Re = y·(c−s) + Z, Im = x·(c+s) − Z.
- Accepts one sample per clock under a valid/ready handshake and applies round-half-up scaling.
- Carries a sideband tag (bin index / frame marker) aligned with the data.

Parameters:
- DATA_W, 8, signed width of x, y and the Re/Im outputs.
- COEF_W, 8, signed width of c; c+s and c−s are COEF_W+1 bits.
- FRAC, 7, fractional bits of the coefficients; product right-shift amount; legal range 1..COEF_W−1.
- TAG_W, 5, width of the sideband tag passed through unchanged.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- i_valid  in  1  input sample valid.
- o_ready  out  1  block can accept an input this cycle.
- i_x  in  DATA_W  real part of the input, signed.
- i_y  in  DATA_W  imaginary part of the input, signed.
- i_c  in  COEF_W  twiddle cosine term, signed.
- i_c_plus_s  in  COEF_W+1  c+s, signed.
- i_c_minus_s  in  COEF_W+1  c−s, signed.
- i_tag  in  TAG_W  sideband tag.
- o_valid  out  1  output sample valid.
- i_ready  in  1  downstream accepts the output.
- o_re  out  DATA_W  real part of the result, signed.
- o_im  out  DATA_W  imaginary part of the result, signed.
- o_tag  out  TAG_W  tag of the output sample.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All pipeline valid bits, o_valid, o_re, o_im and o_tag clear to 0.
  - o_ready is 1 once reset is released.
  - Samples in flight when reset asserts are discarded; none emerge after release.
- Pipeline: 3 register stages; latency is exactly 3 cycles from input acceptance to o_valid with no stall.
  - S1 registers x, y, c, c±s and tag, and computes E = x−y at DATA_W+1 bits, sign-extended, no overflow possible.
  - S2 registers the three products:
    - Z = c·E, DATA_W+COEF_W+1 bits.
    - Pr = y·(c−s) and Pi = x·(c+s), each DATA_W+COEF_W+1 bits.
  - S3:
    - Computes Re = Pr+Z and Im = Pi−Z at DATA_W+COEF_W+2 bits.
    - Adds 2^(FRAC−1), arithmetic-shifts right by FRAC, then reduces to DATA_W bits (wrap or saturate, see Optional Feature).
    - Registers the result into o_re/o_im/o_tag.
- Handshake:
  - Stage enable en = i_ready | ~o_valid, and o_ready = en.
  - When en=1, all stages advance together and a stage's valid bit loads the previous stage's valid (i_valid for S1).
  - When en=0, every stage register and valid bit holds, and the input is not accepted.
  - Input is accepted on a cycle with i_valid & o_ready; output transfers on o_valid & i_ready.
  - Bubbles travel through the pipeline; throughput is 1 sample/clk while i_ready=1.
  - o_re/o_im/o_tag stay stable while o_valid=1 and i_ready=0.
- Data registers may load when their valid bit is 0 (no gating required); outputs are meaningful only with o_valid=1.
- Simultaneous output transfer and new input in the same cycle is legal and loses nothing.
- Twiddle W=1 is encoded as c=2^FRAC−1, c+s=c−s=c (no exact +1 representation).

Optional Feature:
- Macro: TWIDDLE_MULT_SAT_EN.
- Defined:
  - A shifted result above 2^(DATA_W−1)−1 clamps to that value; a result below −2^(DATA_W−1) clamps to that value.
  - Re and Im saturate independently.
- Undefined: the low DATA_W bits of the shifted result are taken (two's-complement wrap), with no extra logic.

Test Plan:
- Identity, DATA_W=8, FRAC=7: x=64, y=−32, c=c+s=c−s=127 -> after 3 cycles o_valid=1, o_re=64, o_im=−32, tag preserved.
- Overflow: x=127, y=−128, c=90, c+s=180, c−s=0 -> o_im=−1; o_re=127 with TWIDDLE_MULT_SAT_EN, o_re=−77 without.
- Streaming: i_valid=1 with an incrementing tag 0..31 and i_ready=1 for 32 cycles -> 32 outputs on consecutive cycles with tags 0..31 in order, each matching the reference model bit-exact.
- Backpressure: stream 8 samples, drop i_ready for 5 cycles mid-stream -> o_ready=0 while stalled, outputs held stable, no loss or duplication, order preserved.
- Reset mid-flight: accept 2 samples, assert rst_n=0 asynchronously between clock edges -> o_valid=0 immediately; after release no stale output appears and o_ready=1.
- Random: 10k random x, y, c, s with random i_valid/i_ready -> every output equals the model in both macro builds.

Source files
------------

// File: rtl/twiddle_mult_pipe.sv
// twiddle_mult_pipe: 3-stage valid/ready complex twiddle multiplier (3-multiplier form, round-half-up).
// Define TWIDDLE_MULT_SAT_EN to saturate Re/Im instead of two's-complement wrap.
module twiddle_mult_pipe #(
   parameter int DATA_W = 8,
   parameter int COEF_W = 8,
   parameter int FRAC   = 7,
   parameter int TAG_W  = 5
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_valid,
   output logic                     o_ready,
   input  logic signed [DATA_W-1:0] i_x,
   input  logic signed [DATA_W-1:0] i_y,
   input  logic signed [COEF_W-1:0] i_c,
   input  logic signed [COEF_W:0]   i_c_plus_s,
   input  logic signed [COEF_W:0]   i_c_minus_s,
   input  logic        [TAG_W-1:0]  i_tag,
   output logic                     o_valid,
   input  logic                     i_ready,
   output logic signed [DATA_W-1:0] o_re,
   output logic signed [DATA_W-1:0] o_im,
   output logic        [TAG_W-1:0]  o_tag
);
   localparam int EW = DATA_W + 1;
   localparam int PW = DATA_W + COEF_W + 1;
   localparam int SW = PW + 1;
   localparam logic signed [SW-1:0] RND = SW'(2 ** (FRAC - 1));
   logic                     en, v1, v2;
   logic signed [DATA_W-1:0] x1, y1;
   logic signed [EW-1:0]     e1;
   logic signed [COEF_W-1:0] c1;
   logic signed [COEF_W:0]   cp1, cm1;
   logic        [TAG_W-1:0]  t1, t2;
   logic signed [PW-1:0]     z2, pr2, pi2;
   logic signed [SW-1:0]     re_f, im_f;
`ifdef TWIDDLE_MULT_SAT_EN
   localparam logic signed [SW-1:0] MAXV = SW'(2 ** (DATA_W - 1) - 1);
   localparam logic signed [SW-1:0] MINV = SW'(-(2 ** (DATA_W - 1)));
   function automatic logic signed [DATA_W-1:0] reduce(input logic signed [SW-1:0] v);
      logic signed [SW-1:0] s;
      s = v >>> FRAC;
      return s > MAXV ? DATA_W'(MAXV) : s < MINV ? DATA_W'(MINV) : DATA_W'(s);
   endfunction
`else
   function automatic logic signed [DATA_W-1:0] reduce(input logic signed [SW-1:0] v);
      return DATA_W'(v >>> FRAC);
   endfunction
`endif
   assign en      = i_ready | ~o_valid;
   assign o_ready = en;
   // Re = y(c-s) + c(x-y), Im = x(c+s) - c(x-y), rounding offset folded into the add
   always_comb begin
      re_f = SW'(pr2) + SW'(z2) + RND;
      im_f = SW'(pi2) - SW'(z2) + RND;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         v1      <= 1'b0;
         x1      <= '0;
         y1      <= '0;
         e1      <= '0;
         c1      <= '0;
         cp1     <= '0;
         cm1     <= '0;
         t1      <= '0;
         v2      <= 1'b0;
         z2      <= '0;
         pr2     <= '0;
         pi2     <= '0;
         t2      <= '0;
         o_valid <= 1'b0;
         o_re    <= '0;
         o_im    <= '0;
         o_tag   <= '0;
      end else if (en) begin
         v1      <= i_valid;
         x1      <= i_x;
         y1      <= i_y;
         e1      <= EW'(i_x) - EW'(i_y);
         c1      <= i_c;
         cp1     <= i_c_plus_s;
         cm1     <= i_c_minus_s;
         t1      <= i_tag;
         v2      <= v1;
         z2      <= PW'(c1) * PW'(e1);
         pr2     <= PW'(y1) * PW'(cm1);
         pi2     <= PW'(x1) * PW'(cp1);
         t2      <= t1;
         o_valid <= v2;
         o_re    <= reduce(re_f);
         o_im    <= reduce(im_f);
         o_tag   <= t2;
      end
endmodule

// File: tb/tb_twiddle_mult_pipe.sv
// tb_twiddle_mult_pipe: directed and randomized checks of twiddle_mult_pipe against a direct complex-multiply model.
module tb_twiddle_mult_pipe;
   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              i_valid = 1'b0, i_ready = 1'b1;
   logic              o_ready, o_valid;
   logic signed [7:0] i_x = '0, i_y = '0, i_c = '0, o_re, o_im;
   logic signed [8:0] i_c_plus_s = '0, i_c_minus_s = '0;
   logic        [4:0] i_tag = '0, o_tag;
   int n_tests = 0, n_fail = 0;

   twiddle_mult_pipe dut (
      .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
      .i_x(i_x), .i_y(i_y), .i_c(i_c), .i_c_plus_s(i_c_plus_s), .i_c_minus_s(i_c_minus_s),
      .i_tag(i_tag), .o_valid(o_valid), .i_ready(i_ready), .o_re(o_re), .o_im(o_im), .o_tag(o_tag)
   );

   always #5 clk = ~clk;

   function automatic logic signed [7:0] red(input longint v);
      longint r;
      r = (v + 64) >>> 7;
`ifdef TWIDDLE_MULT_SAT_EN
      if (r > 127) r = 127;
      if (r < -128) r = -128;
`endif
      return r[7:0];
   endfunction

   function automatic logic signed [7:0] m_re(input int x, y, c, s);
      return red(longint'(x * c - y * s));
   endfunction

   function automatic logic signed [7:0] m_im(input int x, y, c, s);
      return red(longint'(x * s + y * c));
   endfunction

   task automatic put(input logic v, input int x, y, c, s, tag);
      i_valid = v; i_x = 8'(x); i_y = 8'(y); i_c = 8'(c);
      i_c_plus_s = 9'(c + s); i_c_minus_s = 9'(c - s); i_tag = 5'(tag);
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; i_ready = 1'b1; put(0, 0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_tests++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset o_valid: got %b want 0", o_valid); end
      n_tests++; if (o_re !== 8'sd0 || o_im !== 8'sd0) begin n_fail++; $display("FAIL reset data: got re=%0d im=%0d want 0 0", o_re, o_im); end
      n_tests++; if (o_tag !== 5'd0) begin n_fail++; $display("FAIL reset tag: got %0d want 0", o_tag); end
      rst_n = 1'b1;
      step;
      n_tests++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL reset o_ready: got %b want 1", o_ready); end
   endtask

   task automatic test_identity;
      put(1, 64, -32, 127, 0, 21);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (k < 3) begin
            n_tests++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL identity early valid cycle %0d: got %b want 0", k, o_valid); end
         end else begin
            n_tests++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL identity latency: got o_valid=%b want 1", o_valid); end
            n_tests++; if (o_re !== 8'sd64 || o_im !== -8'sd32) begin n_fail++; $display("FAIL identity data: got re=%0d im=%0d want 64 -32", o_re, o_im); end
            n_tests++; if (o_tag !== 5'd21) begin n_fail++; $display("FAIL identity tag: got %0d want 21", o_tag); end
         end
         step;
         put(0, 0, 0, 0, 0, 0);
      end
   endtask

   task automatic test_overflow;
      logic signed [7:0] want_re;
`ifdef TWIDDLE_MULT_SAT_EN
      want_re = 8'sd127;
`else
      want_re = -8'sd77;
`endif
      put(1, 127, -128, 90, 90, 9);
      step;
      put(0, 0, 0, 0, 0, 0);
      step; step;
      @(negedge clk);
      n_tests++; if (o_valid !== 1'b1 || o_tag !== 5'd9) begin n_fail++; $display("FAIL overflow valid/tag: got %b/%0d want 1/9", o_valid, o_tag); end
      n_tests++; if (o_re !== want_re) begin n_fail++; $display("FAIL overflow re: got %0d want %0d", o_re, want_re); end
      n_tests++; if (o_im !== -8'sd1) begin n_fail++; $display("FAIL overflow im: got %0d want -1", o_im); end
      step;
   endtask

   task automatic test_streaming;
      int sx[32], sy[32], sc[32], ss[32];
      for (int j = 0; j < 32; j++) begin
         sx[j] = $urandom_range(0, 255) - 128; sy[j] = $urandom_range(0, 255) - 128;
         sc[j] = $urandom_range(0, 255) - 128; ss[j] = $urandom_range(0, 255) - 128;
      end
      i_ready = 1'b1;
      for (int k = 0; k < 35; k++) begin
         if (k < 32) put(1, sx[k], sy[k], sc[k], ss[k], k); else put(0, 0, 0, 0, 0, 0);
         @(negedge clk);
         if (k >= 3) begin
            n_tests++;
            if (o_valid !== 1'b1 || o_tag !== 5'(k - 3) || o_re !== m_re(sx[k-3], sy[k-3], sc[k-3], ss[k-3])
                || o_im !== m_im(sx[k-3], sy[k-3], sc[k-3], ss[k-3])) begin
               n_fail++;
               $display("FAIL stream out %0d: got v=%b tag=%0d re=%0d im=%0d want v=1 tag=%0d re=%0d im=%0d", k - 3, o_valid, o_tag, o_re, o_im,
                        k - 3, m_re(sx[k-3], sy[k-3], sc[k-3], ss[k-3]), m_im(sx[k-3], sy[k-3], sc[k-3], ss[k-3]));
            end
         end
         step;
      end
      @(negedge clk);
      n_tests++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL stream drain: got o_valid=%b want 0", o_valid); end
      step;
   endtask

   task automatic test_backpressure;
      int sx[8] = '{10, -100, 127, -128, 55, -7, 33, 90};
      int sy[8] = '{-20, 44, -128, 127, 0, 99, -64, 1};
      int sc[8] = '{90, -90, 127, 64, -128, 12, 0, -50};
      int ss[8] = '{90, 90, 0, -64, 127, -12, 127, 100};
      int sent = 0, got = 0;
      logic stalled = 1'b0;
      logic signed [7:0] h_re, h_im;
      logic [4:0] h_tag;
      for (int k = 0; k < 60 && got < 8; k++) begin
         i_ready = !(k >= 5 && k < 10);
         if (sent < 8) put(1, sx[sent], sy[sent], sc[sent], ss[sent], sent + 16); else put(0, 0, 0, 0, 0, 0);
         @(negedge clk);
         if (!i_ready && o_valid) begin
            n_tests++; if (o_ready !== 1'b0) begin n_fail++; $display("FAIL bp o_ready while stalled: got %b want 0", o_ready); end
            if (stalled) begin
               n_tests++;
               if ({o_re, o_im, o_tag} !== {h_re, h_im, h_tag}) begin
                  n_fail++; $display("FAIL bp hold: got re=%0d im=%0d tag=%0d want re=%0d im=%0d tag=%0d", o_re, o_im, o_tag, h_re, h_im, h_tag);
               end
            end
            stalled = 1'b1; h_re = o_re; h_im = o_im; h_tag = o_tag;
         end else stalled = 1'b0;
         if (o_valid && i_ready) begin
            n_tests++;
            if (o_tag !== 5'(got + 16) || o_re !== m_re(sx[got], sy[got], sc[got], ss[got]) || o_im !== m_im(sx[got], sy[got], sc[got], ss[got])) begin
               n_fail++;
               $display("FAIL bp out %0d: got tag=%0d re=%0d im=%0d want tag=%0d re=%0d im=%0d", got, o_tag, o_re, o_im, got + 16,
                        m_re(sx[got], sy[got], sc[got], ss[got]), m_im(sx[got], sy[got], sc[got], ss[got]));
            end
            got++;
         end
         if (i_valid && o_ready) sent++;
         step;
      end
      n_tests++; if (got != 8) begin n_fail++; $display("FAIL bp count: got %0d outputs want 8", got); end
      i_ready = 1'b1; put(0, 0, 0, 0, 0, 0);
      repeat (4) step;
   endtask

   task automatic test_reset_midflight;
      i_ready = 1'b1;
      put(1, 10, 20, 50, 30, 3); step;
      put(1, -5, 7, 100, -20, 4); step;
      put(0, 0, 0, 0, 0, 0); step;
      n_tests++; if (o_valid !== 1'b1 || o_tag !== 5'd3) begin n_fail++; $display("FAIL midreset pre: got v=%b tag=%0d want 1/3", o_valid, o_tag); end
      #2 rst_n = 1'b0;
      #1;
      n_tests++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL midreset async valid: got %b want 0", o_valid); end
      n_tests++; if (o_tag !== 5'd0 || o_re !== 8'sd0) begin n_fail++; $display("FAIL midreset async data: got tag=%0d re=%0d want 0 0", o_tag, o_re); end
      @(posedge clk);
      #2 rst_n = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         n_tests++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL midreset stale output cycle %0d: got o_valid=%b want 0", k, o_valid); end
         step;
      end
      n_tests++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL midreset o_ready: got %b want 1", o_ready); end
   endtask

   task automatic test_random;
      logic signed [7:0] q_re[$], q_im[$];
      logic [4:0] q_tag[$];
      logic signed [7:0] e_re, e_im;
      logic [4:0] e_tag;
      int sent = 0, got = 0, x, y, c, s;
      for (int k = 0; k < 60000 && got < 10000; k++) begin
         x = $urandom_range(0, 255) - 128; y = $urandom_range(0, 255) - 128;
         c = $urandom_range(0, 255) - 128; s = $urandom_range(0, 255) - 128;
         put(sent < 10000 && $urandom_range(0, 3) != 0, x, y, c, s, sent % 32);
         i_ready = $urandom_range(0, 3) != 0;
         @(negedge clk);
         if (o_valid && i_ready) begin
            n_tests++;
            if (q_re.size() == 0) begin
               n_fail++; $display("FAIL random spurious output: got tag=%0d want none", o_tag);
            end else begin
               e_re = q_re.pop_front(); e_im = q_im.pop_front(); e_tag = q_tag.pop_front();
               if ({o_re, o_im, o_tag} !== {e_re, e_im, e_tag}) begin
                  n_fail++; $display("FAIL random out %0d: got re=%0d im=%0d tag=%0d want re=%0d im=%0d tag=%0d", got, o_re, o_im, o_tag, e_re, e_im, e_tag);
               end
            end
            got++;
         end
         if (i_valid && o_ready) begin
            q_re.push_back(m_re(x, y, c, s)); q_im.push_back(m_im(x, y, c, s)); q_tag.push_back(5'(sent % 32));
            sent++;
         end
         step;
      end
      n_tests++; if (got != 10000) begin n_fail++; $display("FAIL random count: got %0d outputs want 10000", got); end
      put(0, 0, 0, 0, 0, 0); i_ready = 1'b1;
   endtask

   initial begin
      test_reset;
      test_identity;
      test_overflow;
      test_streaming;
      test_backpressure;
      test_reset_midflight;
      test_random;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
